// File: rtl/pdm_pkg.sv
// Shared types and defaults for the PDM microphone array scheduler.
package pdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int PDM_DATA_W = 16;

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider with capture FSM and registered edge strobes.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pdm_clk,
  output logic smp_rise,
  output logic smp_fall,
  output logic active
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap   = (cnt == CW'(CLK_DIV - 1));
  assign active = (state != IDLE);

  // STOP keeps the divider running so the mic sees a clean final falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pdm_clk  <= 1'b0;
      smp_rise <= 1'b0;
      smp_fall <= 1'b0;
    end else begin
      smp_rise <= 1'b0;
      smp_fall <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          pdm_clk <= 1'b0;
          if (en) state <= RUN;
        end
        RUN, STOP: begin
          if (wrap) begin
            cnt      <= '0;
            pdm_clk  <= ~pdm_clk;
            smp_rise <= ~pdm_clk;
            smp_fall <= pdm_clk;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (en)                   state <= RUN;
          else if (state == RUN)    state <= STOP;
          else if (wrap && pdm_clk) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pdm_array_sched.sv
// Collects per-channel decimator samples into hold registers and serialises
// them onto one ready/valid stream with round-robin arbitration.
module pdm_array_sched
  import pdm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = PDM_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic                       pdm_clk,
  output logic                       smp_rise,
  output logic                       smp_fall,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(NUM_CH)-1:0]  m_chan,
  output logic                       m_last,
  output logic [NUM_CH-1:0]          ovr,
  input  logic                       ovr_clr,
  output logic                       busy
);

  localparam int CW = $clog2(NUM_CH);

  logic              active;
  logic [DATA_W-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [CW-1:0]     last_grant;
  logic              load;
  logic              gnt_any;
  logic [CW-1:0]     gnt_idx;
  logic [NUM_CH-1:0] gnt_vec;
  logic [NUM_CH-1:0] ovr_set;
  logic [CW-1:0]     cand;
  int                c;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pdm_clk  (pdm_clk),
    .smp_rise (smp_rise),
    .smp_fall (smp_fall),
    .active   (active)
  );

  assign load = !m_valid || m_ready;

  // Search starts just past the last winner so every channel gets a turn
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c    = (int'(last_grant) + k) % NUM_CH;
      cand = CW'(c);
      if (!gnt_any && pend[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (load && gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  // A channel being granted this cycle frees its slot, so a new sample is not an overrun
  assign ovr_set = ch_valid & pend & ~gnt_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
      pend       <= '0;
      ovr        <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_chan     <= '0;
      last_grant <= CW'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          hold[i] <= ch_data[i*DATA_W +: DATA_W];
          pend[i] <= 1'b1;
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
      ovr <= (ovr_clr ? '0 : ovr) | ovr_set;
      if (load) begin
        if (gnt_any) begin
          m_valid    <= 1'b1;
          m_data     <= hold[gnt_idx];
          m_chan     <= gnt_idx;
          last_grant <= gnt_idx;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  assign m_last = (m_chan == CW'(NUM_CH - 1));
  assign busy   = active || (|pend) || m_valid;

endmodule

// File: tb/tb_pdm_array_sched.sv
// Directed bench for pdm_array_sched: divider timing, stop alignment,
// round robin, backpressure/overrun, same-cycle grant and mid-run reset.
module tb_pdm_array_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pdm_clk;
  logic        smp_rise;
  logic        smp_fall;
  logic [3:0]  ch_valid;
  logic [63:0] ch_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  m_chan;
  logic        m_last;
  logic [3:0]  ovr;
  logic        ovr_clr;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int strobes;

  pdm_array_sched #(.NUM_CH(4), .CLK_DIV(16), .DATA_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pdm_clk  (pdm_clk),
    .smp_rise (smp_rise),
    .smp_fall (smp_fall),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_chan   (m_chan),
    .m_last   (m_last),
    .ovr      (ovr),
    .ovr_clr  (ovr_clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] d);
    ch_valid = v;
    ch_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkStream(input string tag, input logic v, input logic [15:0] d,
                             input logic [1:0] ch, input logic l);
    checkOutput({tag, "_valid"}, 32'(m_valid), 32'(v));
    checkOutput({tag, "_data"},  32'(m_data),  32'(d));
    checkOutput({tag, "_chan"},  32'(m_chan),  32'(ch));
    checkOutput({tag, "_last"},  32'(m_last),  32'(l));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; ovr_clr = 1'b0;
    applyStimulus(4'h0, 64'h0);
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_pdm_clk", 32'(pdm_clk), 32'd0);
    checkOutput("rst_strobes", 32'({smp_rise, smp_fall}), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_ovr", 32'(ovr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Round robin, all four channels at once, accepted while IDLE
    m_ready = 1'b1;
    applyStimulus(4'hF, 64'h4444_3333_2222_1111);
    tick(1);
    applyStimulus(4'h0, 64'h0);
    checkOutput("rr_latency", 32'(m_valid), 32'd0);
    checkOutput("rr_busy", 32'(busy), 32'd1);
    tick(1); checkStream("rr0", 1'b1, 16'h1111, 2'd0, 1'b0);
    tick(1); checkStream("rr1", 1'b1, 16'h2222, 2'd1, 1'b0);
    tick(1); checkStream("rr2", 1'b1, 16'h3333, 2'd2, 1'b0);
    tick(1); checkStream("rr3", 1'b1, 16'h4444, 2'd3, 1'b1);
    tick(1); checkOutput("rr_drained", 32'(m_valid), 32'd0);

    // Backpressure with a double pulse on ch1
    m_ready = 1'b0;
    applyStimulus(4'h1, 64'h0000_0000_0000_0A0A);
    tick(1);
    applyStimulus(4'h0, 64'h0);
    tick(1); checkStream("bp_hold0", 1'b1, 16'h0A0A, 2'd0, 1'b0);
    applyStimulus(4'h2, 64'h0000_0000_AAAA_0000);
    tick(1);
    checkOutput("bp_no_ovr_yet", 32'(ovr), 32'h0);
    applyStimulus(4'h2, 64'h0000_0000_BBBB_0000);
    tick(1);
    applyStimulus(4'h0, 64'h0);
    checkOutput("bp_ovr1", 32'(ovr), 32'h2);
    tick(7);
    checkStream("bp_stable", 1'b1, 16'h0A0A, 2'd0, 1'b0);
    m_ready = 1'b1;
    tick(1); checkStream("bp_second", 1'b1, 16'hBBBB, 2'd1, 1'b0);
    tick(1); checkOutput("bp_drained", 32'(m_valid), 32'd0);
    checkOutput("bp_ovr_sticky", 32'(ovr), 32'h2);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    checkOutput("ovr_cleared", 32'(ovr), 32'h0);

    // ch0 pulses again in the cycle its first sample is granted
    applyStimulus(4'h1, 64'h0000_0000_0000_1234);
    tick(1);
    applyStimulus(4'h1, 64'h0000_0000_0000_5678);
    tick(1);
    applyStimulus(4'h0, 64'h0);
    checkStream("sim_old", 1'b1, 16'h1234, 2'd0, 1'b0);
    checkOutput("sim_no_ovr", 32'(ovr), 32'h0);
    tick(1); checkStream("sim_new", 1'b1, 16'h5678, 2'd0, 1'b0);
    tick(1); checkOutput("sim_drained", 32'(m_valid), 32'd0);
    checkOutput("sim_ovr_final", 32'(ovr), 32'h0);

    // Divider: rise 16 clocks into RUN, 32-clock period
    en = 1'b1;
    tick(16);
    checkOutput("div_pre_rise", 32'({pdm_clk, smp_rise}), 32'd0);
    tick(1);
    checkOutput("div_rise", 32'({pdm_clk, smp_rise, smp_fall}), 32'b110);
    checkOutput("div_busy", 32'(busy), 32'd1);
    tick(1);
    checkOutput("div_rise_one_clk", 32'({pdm_clk, smp_rise}), 32'b10);
    tick(15);
    checkOutput("div_fall", 32'({pdm_clk, smp_rise, smp_fall}), 32'b001);
    tick(16);
    checkOutput("div_rise2", 32'({pdm_clk, smp_rise}), 32'b11);

    // en drops while pdm_clk is high: one more fall, then IDLE
    en = 1'b0;
    tick(15);
    checkOutput("stop_pre_fall", 32'({pdm_clk, smp_fall}), 32'b10);
    tick(1);
    checkOutput("stop_fall", 32'({pdm_clk, smp_fall}), 32'b01);
    checkOutput("stop_idle_busy", 32'(busy), 32'd0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (smp_rise || smp_fall || pdm_clk) strobes++;
    end
    checkOutput("idle_quiet", 32'(strobes), 32'd0);

    // en re-asserted during STOP keeps the divider phase
    en = 1'b1;
    tick(17);
    checkOutput("re_rise", 32'({pdm_clk, smp_rise}), 32'b11);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(10);
    checkOutput("re_pre_fall", 32'({pdm_clk, smp_fall}), 32'b10);
    tick(1);
    checkOutput("re_fall", 32'({pdm_clk, smp_fall}), 32'b01);
    checkOutput("re_busy_run", 32'(busy), 32'd1);
    tick(16);
    checkOutput("re_rise2", 32'({pdm_clk, smp_rise}), 32'b11);
    en = 1'b0;
    tick(16);
    checkOutput("re_idle", 32'({pdm_clk, busy}), 32'b00);

    // Reset mid-transfer with a pending entry behind a stalled output
    en = 1'b1;
    m_ready = 1'b0;
    applyStimulus(4'h6, 64'h0000_2222_1111_0000);
    tick(1);
    applyStimulus(4'h0, 64'h0);
    tick(1);
    checkStream("pre_rst", 1'b1, 16'h1111, 2'd1, 1'b0);
    rst = 1'b1;
    #1;
    checkStream("async_rst", 1'b0, 16'h0000, 2'd0, 1'b0);
    checkOutput("async_rst_misc", 32'({pdm_clk, smp_rise, smp_fall, busy, ovr}), 32'h0);
    en = 1'b0;
    tick(2);
    rst = 1'b0;
    m_ready = 1'b1;
    applyStimulus(4'h9, 64'h0DDD_0000_0000_0CCC);
    tick(1);
    applyStimulus(4'h0, 64'h0);
    tick(1); checkStream("post_rst_ch0", 1'b1, 16'h0CCC, 2'd0, 1'b0);
    tick(1); checkStream("post_rst_ch3", 1'b1, 16'h0DDD, 2'd3, 1'b1);
    tick(1); checkOutput("post_rst_discarded", 32'({m_valid, busy}), 32'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
